// File: rtl/binary2bcd_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one input bit per clock, with an overflow flag.
// Define BCD_BLANK_EN to build the registered leading-zero blanking mask; otherwise blank is 0.
module binary2bcd_seq #(
  parameter int unsigned N = 16,
  parameter int unsigned D = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   number,
  output logic           ready,
  output logic           done,
  output logic [4*D-1:0] bcd,
  output logic           ovf,
  output logic [D-1:0]   blank
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   shreg_q;
  logic [4*D-1:0] scratch_q;
  logic [4*D-1:0] adj;
  logic           ovfs_q;
  logic [4*D-1:0] bcd_q;
  logic           ovf_q;
  logic           done_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (cnt_q == CW'(1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    ready = (state_q == StIdle);
    done  = done_q;
    bcd   = bcd_q;
    ovf   = ovf_q;
  end

  // Add 3 to every digit >= 5 so the following left shift yields a valid decimal carry.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < int'(D); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Datapath; results only move to bcd/ovf in StDone so partial values never show.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      shreg_q   <= '0;
      scratch_q <= '0;
      ovfs_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shreg_q   <= number;
            scratch_q <= '0;
            ovfs_q    <= 1'b0;
            cnt_q     <= CW'(N);
          end
        end
        StShift: begin
          scratch_q <= {adj[4*D-2:0], shreg_q[N-1]};
          shreg_q   <= shreg_q << 1;
          // A bit leaving the top digit is a decimal carry past 10**D.
          ovfs_q    <= ovfs_q | adj[4*D-1];
          cnt_q     <= cnt_q - CW'(1);
        end
        StDone: begin
          bcd_q  <= scratch_q;
          ovf_q  <= ovfs_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_BLANK_EN
  logic [D-1:0] blank_d, blank_q;
  logic         all_zero;

  // Digit i is blankable when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    blank_d  = '0;
    all_zero = 1'b1;
    for (int i = int'(D) - 1; i >= 0; i--) begin
      all_zero   = all_zero & (scratch_q[4*i +: 4] == 4'd0);
      blank_d[i] = all_zero && (i != 0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blank_q <= '0;
    end else if (state_q == StDone) begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_binary2bcd_seq.sv
// Self-checking bench for binary2bcd_seq: N=16/D=5 and N=16/D=4 instances, scoreboard of expected
// results pushed on accepted start and popped on done.
module tb_binary2bcd_seq;

  localparam int unsigned N  = 16;
  localparam int unsigned D  = 5;
  localparam int unsigned D4 = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, start4;
  logic [N-1:0]  number, number4;
  logic          ready, done, ovf;
  logic [19:0]   bcd;
  logic [4:0]    blank;
  logic          ready4, done4, ovf4;
  logic [15:0]   bcd4;
  logic [3:0]    blank4;

  typedef struct packed {
    logic [19:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t q5[$];
  exp_t q4[$];
  int   checks = 0;
  int   fails  = 0;

  binary2bcd_seq #(.N(N), .D(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .number (number),
    .ready  (ready),
    .done   (done),
    .bcd    (bcd),
    .ovf    (ovf),
    .blank  (blank)
  );

  binary2bcd_seq #(.N(N), .D(D4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start4),
    .number (number4),
    .ready  (ready4),
    .done   (done4),
    .bcd    (bcd4),
    .ovf    (ovf4),
    .blank  (blank4)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int v, input int d);
    exp_t        e;
    logic [19:0] b;
    int          lim;
    int          r;
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    r = v % lim;
    b = '0;
    for (int i = 0; i < d; i++) begin
      b[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    e.bcd = b;
    e.ovf = (v >= lim);
    return e;
  endfunction

  // Scoreboard push: a start is accepted on a rising edge with ready high and reset inactive.
  always @(posedge clk) begin
    if (rst_n && start && ready) q5.push_back(model(int'(number), int'(D)));
    if (rst_n && start4 && ready4) q4.push_back(model(int'(number4), int'(D4)));
  end

  task automatic pop_exp(input bit use4, output exp_t e);
    e.bcd = 20'hFFFFF;
    e.ovf = 1'bx;
    if (use4) begin
      if (q4.size() > 0) e = q4.pop_front();
    end else begin
      if (q5.size() > 0) e = q5.pop_front();
    end
  endtask

  task automatic wait_done(input bit use4, input int budget, output bit got, output int lat);
    got = 1'b0;
    lat = 0;
    while (!got && lat < budget) begin
      @(negedge clk);
      lat++;
      if ((use4 ? done4 : done) === 1'b1) got = 1'b1;
    end
  endtask

  task automatic issue(input logic [N-1:0] v);
    number = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b, want 1", ready); end
    checks++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, want 0", done); end
    checks++;
    if (bcd !== 20'h0) begin fails++; $display("FAIL reset_bcd: got %h, want 00000", bcd); end
    checks++;
    if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b, want 0", ovf); end
    checks++;
    if (blank !== 5'b0) begin fails++; $display("FAIL reset_blank: got %b, want 00000", blank); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency;
    exp_t e;
    bit   busy_ok = 1'b1;
    number = '0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    // N SHIFT cycles plus DONE: ready low, no done
    for (int i = 0; i < int'(N) + 1; i++) begin
      if (i > 0) @(negedge clk);
      if (ready !== 1'b0 || done !== 1'b0) busy_ok = 1'b0;
    end
    checks++;
    if (!busy_ok) begin fails++; $display("FAIL latency_busy: ready/done not 0/0 for N+1 cycles"); end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      fails++;
      $display("FAIL latency_done: done=%b ready=%b, want 1 1", done, ready);
    end
    pop_exp(1'b0, e);
    checks++;
    if (bcd !== e.bcd || ovf !== e.ovf) begin
      fails++;
      $display("FAIL latency_result: bcd=%h ovf=%b, want %h %b", bcd, ovf, e.bcd, e.ovf);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin fails++; $display("FAIL done_pulse: done=%b, want 0", done); end
  endtask

  task automatic test_values;
    logic [N-1:0] vals [6];
    exp_t e;
    bit   got;
    int   lat;
    vals = '{16'd65535, 16'd9, 16'd10, 16'd1000, 16'd4096, 16'd12345};
    for (int i = 0; i < 6; i++) begin
      issue(vals[i]);
      wait_done(1'b0, int'(N) + 10, got, lat);
      pop_exp(1'b0, e);
      checks++;
      if (!got || lat != int'(N) + 1) begin
        fails++;
        $display("FAIL value_latency %0d: done=%b after %0d cycles, want %0d", vals[i], got, lat,
                 N + 1);
      end
      checks++;
      if (bcd !== e.bcd || ovf !== e.ovf) begin
        fails++;
        $display("FAIL value %0d: bcd=%h ovf=%b, want %h %b", vals[i], bcd, ovf, e.bcd, e.ovf);
      end
    end
  endtask

  task automatic test_ovf;
    logic [N-1:0] vals [3];
    exp_t e;
    bit   got;
    int   lat;
    vals = '{16'd12345, 16'd9999, 16'd10000};
    for (int i = 0; i < 3; i++) begin
      number4 = vals[i];
      start4  = 1'b1;
      @(negedge clk);
      start4  = 1'b0;
      wait_done(1'b1, int'(N) + 10, got, lat);
      pop_exp(1'b1, e);
      checks++;
      if (!got || bcd4 !== e.bcd[15:0] || ovf4 !== e.ovf) begin
        fails++;
        $display("FAIL ovf_d4 %0d: done=%b bcd=%h ovf=%b, want %h %b", vals[i], got, bcd4, ovf4,
                 e.bcd[15:0], e.ovf);
      end
    end
  endtask

  task automatic test_ignore_busy;
    exp_t e;
    bit   got;
    int   lat;
    bit   busy_ok = 1'b1;
    bit   extra = 1'b0;
    issue(16'd1000);
    for (int i = 0; i < 10; i++) begin
      number = 16'(4321 + i);
      start  = (i % 2 == 0);
      @(negedge clk);
      if (ready !== 1'b0) busy_ok = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (!busy_ok) begin fails++; $display("FAIL busy_ready: ready rose during conversion"); end
    wait_done(1'b0, int'(N) + 10, got, lat);
    pop_exp(1'b0, e);
    checks++;
    if (!got || bcd !== e.bcd || ovf !== e.ovf) begin
      fails++;
      $display("FAIL busy_result: done=%b bcd=%h ovf=%b, want %h %b", got, bcd, ovf, e.bcd, e.ovf);
    end
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) extra = 1'b1;
    end
    checks++;
    if (extra || q5.size() != 0) begin
      fails++;
      $display("FAIL busy_queued: extra done=%b pending=%0d, want 0 0", extra, q5.size());
    end
  endtask

  task automatic test_reset_mid;
    bit spurious = 1'b0;
    issue(16'd777);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || bcd !== 20'h0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: ready=%b done=%b bcd=%h ovf=%b, want 1 0 00000 0", ready, done,
               bcd, ovf);
    end
    rst_n = 1'b1;
    q5.delete();
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin fails++; $display("FAIL mid_reset_done: done pulsed, want none"); end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] vals [4];
    exp_t e;
    bit   got;
    int   lat;
    vals   = '{16'd123, 16'd4567, 16'd65000, 16'd1};
    number = vals[0];
    start  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_done(1'b0, int'(N) + 10, got, lat);
      pop_exp(1'b0, e);
      checks++;
      if (!got || lat != int'(N) + 2 || bcd !== e.bcd || ovf !== e.ovf) begin
        fails++;
        $display("FAIL b2b %0d: done=%b gap=%0d bcd=%h ovf=%b, want gap %0d bcd %h ovf %b",
                 vals[i], got, lat, bcd, ovf, N + 2, e.bcd, e.ovf);
      end
      if (i < 3) number = vals[i+1];
      else start = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_blank;
    logic [N-1:0] vals [3];
    logic [4:0]   want [3];
    exp_t e;
    bit   got;
    int   lat;
    vals = '{16'd42, 16'd0, 16'd65535};
`ifdef BCD_BLANK_EN
    want = '{5'b11100, 5'b11110, 5'b00000};
`else
    want = '{5'b00000, 5'b00000, 5'b00000};
`endif
    for (int i = 0; i < 3; i++) begin
      issue(vals[i]);
      wait_done(1'b0, int'(N) + 10, got, lat);
      pop_exp(1'b0, e);
      checks++;
      if (!got || blank !== want[i] || bcd !== e.bcd) begin
        fails++;
        $display("FAIL blank %0d: done=%b blank=%b bcd=%h, want %b %h", vals[i], got, blank, bcd,
                 want[i], e.bcd);
      end
    end
  endtask

  task automatic test_sweep;
    exp_t         e;
    bit           got;
    int           lat;
    logic [N-1:0] v;
    for (int i = 0; i < 1700; i++) begin
      v = (i < 200) ? 16'(i) : 16'($urandom_range(65535, 0));
      issue(v);
      wait_done(1'b0, int'(N) + 10, got, lat);
      pop_exp(1'b0, e);
      checks++;
      if (!got || bcd !== e.bcd || ovf !== e.ovf) begin
        fails++;
        $display("FAIL sweep %0d: done=%b bcd=%h ovf=%b, want %h %b", v, got, bcd, ovf, e.bcd,
                 e.ovf);
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    number  = '0;
    start4  = 1'b0;
    number4 = '0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_values();
    test_ovf();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_blank();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
